oam_dma_ctrl: RTL

//  Sequences the shared CPU bus for a 256-byte page copy (OAM DMA) into a fixed write port.
//  A CPU write to the trigger register halts the CPU via RDY, then takes the bus.
//  It performs 256 read/write pairs from {page,8'h00}..{page,8'hFF} to DEST_ADDR.
//  It then returns the bus to the CPU. Sits beside the CPU in system; drives the bus mux select.

---
 rtl/oam_dma_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: halts the CPU and copies a 256-byte source page to a fixed write port (OAM DMA)
// Ports:
//   i_clk        system clock
//   i_n_reset    asynchronous active-low reset
//   i_trig       1-cycle strobe from the trigger register decode
//   i_trig_page  source page, valid with i_trig
//   i_cpu_rw     CPU cycle direction (1 = read, 0 = write)
//   o_rdy        CPU RDY; 0 halts the CPU
//   o_busy       high in every state except idle
//   o_bus_sel    1 = this block owns addr/rw/wdata on the system bus
//   o_addr       DMA address
//   o_rw         DMA direction (1 = read, 0 = write)
//   o_wdata      DMA write data
//   i_rdata      system bus read data, captured at the end of a read cycle
module oam_dma_ctrl #(
  parameter int          DATA_N    = 8,
  parameter int          ADDR_N    = 16,
  parameter logic [15:0] DEST_ADDR = 16'h2004
) (
  input  logic              i_clk,
  input  logic              i_n_reset,
  input  logic              i_trig,
  input  logic [DATA_N-1:0] i_trig_page,
  input  logic              i_cpu_rw,
  output logic              o_rdy,
  output logic              o_busy,
  output logic              o_bus_sel,
  output logic [ADDR_N-1:0] o_addr,
  output logic              o_rw,
  output logic [DATA_N-1:0] o_wdata,
  input  logic [DATA_N-1:0] i_rdata
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_par;
  logic [7:0]        r_idx;
  logic [DATA_N-1:0] r_page;
  logic [DATA_N-1:0] r_buf;
  // Reads must land on par=0 cycles: leaving HALT with par=1 means the next
  // cycle has par=0, otherwise a dummy ALIGN cycle shifts the read by one.
  // CPU write cycles ignore RDY, so HALT waits for a CPU read cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_trig ? S_HALT : S_IDLE;
      S_HALT:  w_next = !i_cpu_rw ? S_HALT : (r_par ? S_READ : S_ALIGN);
      S_ALIGN: w_next = S_READ;
      S_READ:  w_next = S_WRITE;
      S_WRITE: w_next = (r_idx == 8'hFF) ? S_DONE : S_READ;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      r_state <= S_IDLE;
      r_par   <= 1'b0;
      r_idx   <= 8'h00;
      r_page  <= '0;
      r_buf   <= '0;
    end else begin
      r_par   <= ~r_par;
      r_state <= w_next;
      if (r_state == S_IDLE && i_trig) begin
        r_page <= i_trig_page;
        r_idx  <= 8'h00;
      end
      if (r_state == S_READ) r_buf <= i_rdata;
      // 8-bit wrap keeps the page fixed even for page 8'hFF
      if (r_state == S_WRITE) r_idx <= r_idx + 8'd1;
    end
  end
  assign o_rdy     = (r_state == S_IDLE) || (r_state == S_DONE);
  assign o_busy    = (r_state != S_IDLE);
  assign o_bus_sel = (r_state == S_READ) || (r_state == S_WRITE);
  assign o_rw      = (r_state != S_WRITE);
  assign o_addr    = (r_state == S_WRITE) ? ADDR_N'(DEST_ADDR) : ADDR_N'({r_page, r_idx});
  assign o_wdata   = r_buf;
endmodule
